// File: rtl/swipt_link_pkg.sv
// Constants, frame layout and state encoding shared by the SWIPT link transmitter and receiver.
package swipt_link_pkg;
  localparam int         SWIPT_BIT_PERIOD = 200000;
  localparam int         SWIPT_FRAME_BITS = 36;
  localparam int         SWIPT_CHK_BITS   = 8;
  localparam logic [1:0] PROG_DATA        = 2'b11;

  typedef enum logic [1:0] {IDLE, START, DATA, GUARD} tx_state_e;

  typedef struct packed {
    logic [1:0]                mode;
    logic [1:0]                ftype;
    logic [23:0]               payload;
    logic [SWIPT_CHK_BITS-1:0] chk;
  } frame_t;

  function automatic logic [SWIPT_CHK_BITS-1:0] popcount28(input logic [27:0] v);
    logic [SWIPT_CHK_BITS-1:0] c;
    c = '0;
    for (int i = 0; i < 28; i++) c = c + {{(SWIPT_CHK_BITS-1){1'b0}}, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/swipt_bit_timer.sv
// Bit-period down-counter: loads BIT_PERIOD-1, ticks on the last cycle of each period and reloads.
module swipt_bit_timer #(
  parameter int BIT_PERIOD = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic load,
  input  logic run,
  output logic tick
);
  localparam logic [19:0] RELOAD = 20'(BIT_PERIOD - 1);

  logic [19:0] cnt;

  assign tick = run && (cnt == 20'd0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)              cnt <= 20'd0;
    else if (load || tick)  cnt <= RELOAD;
    else if (run)           cnt <= cnt - 20'd1;
  end
endmodule

// File: rtl/swipt_frame_tx.sv
// SWIPT frame transmitter: start bit, 36-bit {mode,type,payload,popcount} word MSB first, idle-low guard.
// prog/ftype carry the program and type fields (both names are SystemVerilog keywords).
module swipt_frame_tx
  import swipt_link_pkg::*;
#(
  parameter int BIT_PERIOD = SWIPT_BIT_PERIOD,
  parameter int GUARD_BITS = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptAlive,
  input  logic [1:0]  prog,
  input  logic        send,
  input  logic [1:0]  mode,
  input  logic [1:0]  ftype,
  input  logic [23:0] payload,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        dout
);
  localparam int         GL         = (GUARD_BITS > 0) ? GUARD_BITS - 1 : 0;
  localparam logic [7:0] GUARD_LOAD = 8'(GL);
  localparam logic [5:0] LAST_IDX   = 6'(SWIPT_FRAME_BITS - 1);

  tx_state_e                   state, state_nxt;
  logic                        enable, ready_q, accept, abort, tick;
  logic [SWIPT_FRAME_BITS-1:0] sr;
  logic [5:0]                  bit_cnt;
  logic [7:0]                  guard_cnt;
  frame_t                      frame_in;

  assign enable   = swiptAlive && (prog == PROG_DATA);
  assign ready    = ready_q && enable && (state == IDLE);
  assign busy     = (state != IDLE);
  assign frame_in = '{mode: mode, ftype: ftype, payload: payload,
                      chk: popcount28({mode, ftype, payload})};

  swipt_bit_timer #(.BIT_PERIOD(BIT_PERIOD)) u_timer (
    .clk (clk),
    .nrst(nrst),
    .load(accept),
    .run (busy),
    .tick(tick)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= enable;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE:  if (send && ready) begin accept = 1'b1; state_nxt = START; end
      START: if (tick) state_nxt = DATA;
      DATA:  if (tick && bit_cnt == 6'd0) state_nxt = (GUARD_BITS == 0) ? IDLE : GUARD;
      GUARD: if (tick && guard_cnt == 8'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Disable beats any simultaneous period end.
    if (state != IDLE && !enable) begin
      state_nxt = IDLE;
      abort     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sr        <= '0;
      bit_cnt   <= 6'd0;
      guard_cnt <= 8'd0;
      dout      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (abort) begin
        dout    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            dout <= accept;
            if (accept) sr <= frame_in;
          end
          START: if (tick) begin
            dout    <= sr[SWIPT_FRAME_BITS-1];
            bit_cnt <= LAST_IDX;
          end
          DATA: if (tick) begin
            if (bit_cnt == 6'd0) begin
              dout      <= 1'b0;
              guard_cnt <= GUARD_LOAD;
              done      <= (GUARD_BITS == 0);
            end else begin
              sr      <= {sr[SWIPT_FRAME_BITS-2:0], 1'b0};
              dout    <= sr[SWIPT_FRAME_BITS-2];
              bit_cnt <= bit_cnt - 6'd1;
            end
          end
          GUARD: if (tick) begin
            if (guard_cnt == 8'd0) done <= 1'b1;
            else                   guard_cnt <= guard_cnt - 8'd1;
          end
          default: dout <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_swipt_frame_tx.sv
// Bench for swipt_frame_tx with BIT_PERIOD=4, GUARD_BITS=2: vector table plus hand-written corner sequences.
module tb_swipt_frame_tx;
  localparam int BP = 4;
  localparam int K_DONE = 0, K_ABORT = 1, K_RESET = 2;

  logic        clk = 1'b0, nrst = 1'b0, swiptAlive = 1'b1, send = 1'b0;
  logic [1:0]  prog = 2'b11, mode = 2'b00, ftype = 2'b00;
  logic [23:0] payload = 24'h0;
  logic        ready, busy, done, aborted, dout;

  typedef struct { logic [1:0] m; logic [1:0] t; logic [23:0] p; logic [35:0] f; } vec_t;
  typedef struct { logic [35:0] f; int kind; } exp_t;

  vec_t vecs[4];
  exp_t sb[$];
  int   errors = 0, checks = 0;

  swipt_frame_tx #(.BIT_PERIOD(BP), .GUARD_BITS(2)) dut (
    .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .prog(prog), .send(send),
    .mode(mode), .ftype(ftype), .payload(payload), .ready(ready), .busy(busy),
    .done(done), .aborted(aborted), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic do_send(input logic [1:0] m, input logic [1:0] t, input logic [23:0] p,
                         input logic [35:0] ef, input int kind);
    exp_t e;
    int w = 0;
    while (!ready && w < 50) begin @(negedge clk); w++; end
    chk("ready_before_send", ready, 1);
    mode = m; ftype = t; payload = p; send = 1'b1;
    e.f = ef; e.kind = kind;
    sb.push_back(e);
    @(posedge clk); #1 send = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    do begin @(negedge clk); c++; end while (!done && c < 400);
    chk({name, "_done_latency"}, c, 157);
    chk({name, "_ready_with_done"}, ready, 1);
  endtask

  // Monitor: rebuilds each frame from the line and retires it against the scoreboard.
  initial begin : monitor
    bit          in_frame = 0, shape_ok = 1;
    int          n = 0, k, kind;
    logic [35:0] bits = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (busy) begin
        if (!in_frame) begin in_frame = 1; n = 0; bits = '0; shape_ok = 1; end
        if (n < BP) begin
          if (dout !== 1'b1) shape_ok = 0;
        end else if (n < 37*BP) begin
          k = (n - BP) / BP;
          if ((n - BP) % BP == 0) bits[35-k] = dout;
          else if (dout !== bits[35-k]) shape_ok = 0;
        end else if (dout !== 1'b0) shape_ok = 0;
        n++;
      end else if (in_frame) begin
        in_frame = 0;
        kind = done ? K_DONE : (aborted ? K_ABORT : K_RESET);
        if (sb.size() == 0) chk("unexpected_frame", 1, 0);
        else begin
          e = sb.pop_front();
          chk("frame_end_kind", kind, e.kind);
          if (e.kind == K_DONE) begin
            chk("frame_word", bits, e.f);
            chk("frame_shape_len", {shape_ok, 31'd0, n}, {1'b1, 31'd0, 32'd156});
          end
        end
      end
    end
  end

  initial begin
    int bad;
    vecs[0] = '{2'b00, 2'b01, 24'hA500FF, 36'h1A500FF0D};
    vecs[1] = '{2'b11, 2'b11, 24'hFFFFFF, 36'hFFFFFFF1C};
    vecs[2] = '{2'b00, 2'b00, 24'h000000, 36'h000000000};
    vecs[3] = '{2'b10, 2'b01, 24'h123456, 36'h91234560B};

    // Reset state
    #1;
    chk("rst_ready", ready, 0); chk("rst_busy", busy, 0); chk("rst_dout", dout, 0);
    chk("rst_done", done, 0);   chk("rst_aborted", aborted, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    #1 chk("ready_before_first_edge", ready, 0);
    @(negedge clk);
    chk("ready_after_first_edge", ready, 1);

    // Table-driven frames
    foreach (vecs[i]) begin
      do_send(vecs[i].m, vecs[i].t, vecs[i].p, vecs[i].f, K_DONE);
      wait_done($sformatf("vec%0d", i));
    end

    // Gating: program != 11, then link power absent
    bad = 0; prog = 2'b10; send = 1'b1;
    repeat (50) begin @(negedge clk); if (ready || dout || busy) bad++; end
    send = 1'b0; prog = 2'b11;
    chk("gate_program", bad, 0);
    bad = 0; swiptAlive = 1'b0; send = 1'b1;
    repeat (50) begin @(negedge clk); if (ready || dout || busy) bad++; end
    send = 1'b0; swiptAlive = 1'b1;
    chk("gate_alive", bad, 0);
    repeat (2) @(negedge clk);

    // Abort during data bit 10 (cycles 45..48 after accept)
    do_send(vecs[0].m, vecs[0].t, vecs[0].p, vecs[0].f, K_ABORT);
    repeat (46) @(negedge clk);
    swiptAlive = 1'b0;
    @(negedge clk);
    chk("abort_dout", dout, 0); chk("abort_pulse", aborted, 1); chk("abort_busy", busy, 0);
    bad = 0;
    repeat (5) begin @(negedge clk); if (done || ready || aborted) bad++; end
    chk("abort_quiet", bad, 0);
    swiptAlive = 1'b1;
    @(negedge clk);
    chk("abort_ready_back", ready, 1);

    // Back-to-back, latching, send while busy ignored
    do_send(vecs[3].m, vecs[3].t, vecs[3].p, vecs[3].f, K_DONE);
    begin
      int c = 0;
      do begin
        @(negedge clk); c++;
        if (c == 60) begin
          chk("ready_while_busy", ready, 0);
          payload = 24'h0F0F0F; mode = 2'b11; send = 1'b1;
        end
        if (c == 61) send = 1'b0;
      end while (!done && c < 400);
      chk("b2b_first_latency", c, 157);
    end
    do_send(2'b01, 2'b10, 24'h800001, 36'h680000104, K_DONE);
    wait_done("b2b_second");
    bad = 0;
    repeat (10) begin @(negedge clk); if (busy || dout) bad++; end
    chk("busy_send_not_queued", bad, 0);

    // Asynchronous reset mid-frame
    do_send(vecs[1].m, vecs[1].t, vecs[1].p, vecs[1].f, K_RESET);
    repeat (80) @(posedge clk);
    #2 nrst = 1'b0;
    #1 chk("midrst_dout", dout, 0); chk("midrst_busy", busy, 0);
    @(negedge clk);
    nrst = 1'b1;
    bad = 0;
    repeat (6) begin @(negedge clk); if (done || aborted || busy || dout) bad++; end
    chk("midrst_quiet", bad, 0);
    chk("midrst_ready", ready, 1);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/swipt_frame_tx.md
# swipt_frame_tx

Serial frame transmitter for the SWIPT data link: it serialises a mode/type header, a 24-bit payload and a popcount checksum into one-bit-per-period line code on `dout`. It is the sending-side counterpart of the data-analysis receiver. Its frame format, start-bit convention, bit period and checksum rule match what that receiver samples and accumulates. It sits between the program/mode controller and the line driver.

## Interface
- `BIT_PERIOD`, default 200000: clock cycles per transmitted bit; must be ≥ 2 and < 2^20.
- `GUARD_BITS`, default 2: idle-low bit periods appended after each frame before `ready` returns.
- `clk` in 1: system clock; all logic on rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `swiptAlive` in 1: link power present; low aborts/blocks transmission.
- `program` in 2: transmission enabled only when `2'b11`.
- `send` in 1: start request, sampled when `ready`=1.
- `mode` in 2: frame mode field, latched on accept.
- `type` in 2: frame type field, latched on accept.
- `payload` in 24: frame payload, latched on accept.
- `ready` out 1: IDLE and enabled; a `send` is accepted this cycle.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse when the guard interval completes normally.
- `aborted` out 1: one-cycle pulse when an active frame is killed by disable.
- `dout` out 1: serial line output.

## Operation
- `enable` = `swiptAlive` & (`program` == 2'b11).
- Frame word, 36 bits, sent MSB first: {`mode`, `type`, `payload`[23:0], `chk`[7:0]}.
- `chk` = popcount of the 28 header+payload bits, zero-extended to 8 bits (range 0..28).
- The frame word and `chk` are computed and latched in the accept cycle. Later input changes have no effect on the frame in flight.
- Line code: start bit `1` for one period, then 36 data bits, then `GUARD_BITS` periods of `0`. `dout`=0 in IDLE.
- States and transitions:
  - IDLE → START on `send` & `ready`.
  - START → DATA after `BIT_PERIOD` cycles.
  - DATA → GUARD after 36 periods; the bit index counts 35 down to 0.
  - GUARD → IDLE after `GUARD_BITS`×`BIT_PERIOD` cycles, with `done` pulsed.
  - With `GUARD_BITS`=0, DATA → IDLE directly, and `done` pulses in the cycle the last bit period ends.
- `enable` low in any non-IDLE state forces the next state to IDLE, with `dout`=0 next cycle, `aborted` pulsed, and no `done`.
- `send` while not `ready` is ignored (not queued).
- `enable` low in IDLE holds `ready`=0; `send` is ignored.

## Timing
- Reset values: state IDLE, `dout`=0, `ready`=0 until the first clock edge with `enable`=1, `busy`=0, `done`=0, `aborted`=0, timers and shift register 0.
- Accept at edge N: `dout`=1 and `busy`=1 from edge N+1.
- Data bit k (k=0 is the MSB) is driven during cycles N+1+(k+1)·`BIT_PERIOD` … N+(k+2)·`BIT_PERIOD`.
- Total occupancy is (37+`GUARD_BITS`)·`BIT_PERIOD` cycles. `done` is high the cycle after the last guard cycle, together with `ready`.
- Earliest back-to-back accept is the cycle `done` is high; `send` in that cycle is accepted.
- Simultaneous period end and `enable` fall: abort wins.
- Period counter is 20 bits: loads `BIT_PERIOD`−1, decrements to 0, reloads. No wrap-around is permitted.

## Structure
- Shared package `swipt_link_pkg` holds `SWIPT_BIT_PERIOD`=200000, `SWIPT_FRAME_BITS`=36, `SWIPT_CHK_BITS`=8, `PROG_DATA`=2'b11, and the state enum {IDLE, START, DATA, GUARD}. The receiver uses the same constants.
- One sub-module, `swipt_bit_timer`, contains the period down-counter with a `load` input and a `tick` pulse output. The rest is a single FSM with a 36-bit shift register, a 6-bit bit counter and a guard counter.

## Test plan
All tests use `BIT_PERIOD`=4 and `GUARD_BITS`=2.
- Nominal frame: `mode`=00, `type`=01, `payload`=0xA500FF, `send` pulse. Required: `dout` = 1 for 4 cycles, then frame 0x1A500FF0D MSB first (4 cycles per bit), then 8 cycles of 0. `done` at accept+157, then `ready`.
- Checksum extremes: `payload`=0xFFFFFF with `mode`=`type`=11 gives `chk`=0x1C. All-zero fields give `chk`=0x00 and `dout`=0 after the start bit.
- Abort: `swiptAlive` dropped during data bit 10. Required: `dout`=0 and `aborted`=1 next cycle, no `done`, `ready` returns once `swiptAlive`=1.
- Gating: `program`=10 or `swiptAlive`=0 with `send` held high for 50 cycles. Required: `ready`=0, `dout`=0, `busy`=0 throughout.
- Back-to-back and latching: second `send` in the `done` cycle is accepted. `payload` changed mid-frame does not alter the frame in flight. `send` while busy is ignored.
- Reset mid-frame: `nrst` asserted asynchronously mid-cycle during DATA. Required: `dout`=0 and `busy`=0 immediately; after release, IDLE with no pulses.
